// File: rtl/serial_divide_seq.sv
// Request sequencer for serial_divide_uu.
// Takes tagged operand pairs over a valid/ready request port and hands them to the divider.
// It waits for the divider's done and returns the quotient with its tag over a valid/ready
// response port. A zero divisor never reaches the divider and is flagged instead.
// A divider that never reports done is aborted after TIMEOUT_PP enabled cycles.
module serial_divide_seq #(
  parameter int M_PP       = 16,
  parameter int N_PP       = 8,
  parameter int R_PP       = 0,
  parameter int S_PP       = 0,
  parameter int TAG_W_PP   = 4,
  parameter int TIMEOUT_PP = 64,
  localparam int Q_W       = M_PP + R_PP - S_PP
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clk_en_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [M_PP-1:0]     req_dividend_i,
  input  logic [N_PP-1:0]     req_divisor_i,
  input  logic [TAG_W_PP-1:0] req_tag_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [Q_W-1:0]      rsp_quotient_o,
  output logic [TAG_W_PP-1:0] rsp_tag_o,
  output logic                rsp_dbz_o,
  output logic                rsp_tmo_o,
  output logic                div_divide_o,
  output logic [M_PP-1:0]     div_dividend_o,
  output logic [N_PP-1:0]     div_divisor_o,
  input  logic [Q_W-1:0]      div_quotient_i,
  input  logic                div_done_i,
  output logic                busy_o
);

  localparam int TMR_W = $clog2(TIMEOUT_PP + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_PP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_LO,
    ST_WAIT_HI,
    ST_RESP
  } state_t;

  state_t state_q, state_d;

  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [M_PP-1:0]     dividend_q, dividend_d;
  logic [N_PP-1:0]     divisor_q, divisor_d;
  logic [TAG_W_PP-1:0] tag_q, tag_d;
  logic [Q_W-1:0]      quot_q, quot_d;
  logic                dbz_q, dbz_d;
  logic                tmo_q, tmo_d;
  logic                timeout_hit;
  logic                divisor_zero;

  // The wait timer has used its last allowed enabled cycle.
  assign timeout_hit  = (timer_q == TMR_LAST);
  assign divisor_zero = (req_divisor_i == '0);

  // State register; reset is asynchronous so an abort does not need a clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; every transition is qualified by the shared clock enable.
  always_comb begin
    state_d = state_q;
    if (clk_en_i) begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            state_d = divisor_zero ? ST_RESP : ST_ISSUE;
          end
        end
        ST_ISSUE: state_d = ST_WAIT_LO;
        // A done left high by the previous operation is ignored until it drops.
        ST_WAIT_LO: begin
          if (timeout_hit) begin
            state_d = ST_RESP;
          end else if (!div_done_i) begin
            state_d = ST_WAIT_HI;
          end
        end
        // A real done wins over a timeout landing on the same cycle.
        ST_WAIT_HI: begin
          if (div_done_i || timeout_hit) begin
            state_d = ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from the state register; handshake ready also needs the enable.
  always_comb begin
    div_divide_o = (state_q == ST_ISSUE);
    rsp_valid_o  = (state_q == ST_RESP);
    busy_o       = (state_q != ST_IDLE);
    req_ready_o  = (state_q == ST_IDLE) && clk_en_i;
  end

  // Operand, tag, result and timer updates; everything holds while the enable is low.
  always_comb begin
    timer_d    = timer_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    tag_d      = tag_q;
    quot_d     = quot_q;
    dbz_d      = dbz_q;
    tmo_d      = tmo_q;
    if (clk_en_i) begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            dividend_d = req_dividend_i;
            divisor_d  = req_divisor_i;
            tag_d      = req_tag_i;
            if (divisor_zero) begin
              quot_d = '1;
              dbz_d  = 1'b1;
              tmo_d  = 1'b0;
            end
          end
        end
        ST_ISSUE: timer_d = '0;
        ST_WAIT_LO, ST_WAIT_HI: begin
          if ((state_q == ST_WAIT_HI) && div_done_i) begin
            quot_d = div_quotient_i;
            dbz_d  = 1'b0;
            tmo_d  = 1'b0;
          end else if (timeout_hit) begin
            quot_d = '0;
            dbz_d  = 1'b0;
            tmo_d  = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers; cleared on reset so every output starts at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer_q    <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      tag_q      <= '0;
      quot_q     <= '0;
      dbz_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      tag_q      <= tag_d;
      quot_q     <= quot_d;
      dbz_q      <= dbz_d;
      tmo_q      <= tmo_d;
    end
  end

  assign div_dividend_o = dividend_q;
  assign div_divisor_o  = divisor_q;
  assign rsp_quotient_o = quot_q;
  assign rsp_tag_o      = tag_q;
  assign rsp_dbz_o      = dbz_q;
  assign rsp_tmo_o      = tmo_q;

endmodule

// File: tb/tb_serial_divide_seq.sv
// Bench for serial_divide_seq with a behavioural stand-in for the serial divider.
module tb_serial_divide_seq;

  localparam int M   = 16;
  localparam int N   = 8;
  localparam int TW  = 4;
  localparam int TO  = 64;
  localparam int QW  = 16;
  localparam int LAT = 16;

  logic          clk = 1'b0;
  logic          rst, clk_en;
  logic          req_valid, req_ready;
  logic [M-1:0]  req_dividend;
  logic [N-1:0]  req_divisor;
  logic [TW-1:0] req_tag;
  logic          rsp_valid, rsp_ready;
  logic [QW-1:0] rsp_quotient;
  logic [TW-1:0] rsp_tag;
  logic          rsp_dbz, rsp_tmo;
  logic          div_divide;
  logic [M-1:0]  div_dividend;
  logic [N-1:0]  div_divisor;
  logic [QW-1:0] div_quotient;
  logic          div_done;
  logic          busy;

  always #5 clk = ~clk;

  serial_divide_seq #(.M_PP(M), .N_PP(N), .R_PP(0), .S_PP(0), .TAG_W_PP(TW), .TIMEOUT_PP(TO)) dut (
    .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_dividend_i(req_dividend), .req_divisor_i(req_divisor), .req_tag_i(req_tag),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_quotient_o(rsp_quotient), .rsp_tag_o(rsp_tag),
    .rsp_dbz_o(rsp_dbz), .rsp_tmo_o(rsp_tmo),
    .div_divide_o(div_divide), .div_dividend_o(div_dividend), .div_divisor_o(div_divisor),
    .div_quotient_i(div_quotient), .div_done_i(div_done), .busy_o(busy)
  );

  // Divider stand-in: done drops on divide, rises LAT enabled cycles later with the result.
  logic          stub_busy, stub_done_q, stub_stuck;
  logic [4:0]    stub_cnt;
  logic [QW-1:0] stub_q, stub_res;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_busy <= 1'b0; stub_done_q <= 1'b0; stub_cnt <= '0; stub_q <= '0; stub_res <= '0;
    end else if (clk_en) begin
      if (div_divide) begin
        stub_busy   <= 1'b1;
        stub_cnt    <= '0;
        stub_done_q <= 1'b0;
        stub_res    <= (div_divisor == 0) ? '1 : QW'(int'(div_dividend) / int'(div_divisor));
      end else if (stub_busy) begin
        if (stub_cnt == 5'(LAT - 1)) begin
          stub_busy   <= 1'b0;
          stub_done_q <= 1'b1;
          stub_q      <= stub_res;
        end else begin
          stub_cnt <= stub_cnt + 1'b1;
        end
      end
    end
  end
  assign div_done     = stub_done_q & ~stub_stuck;
  assign div_quotient = stub_q;

  typedef struct {
    logic [QW-1:0] q;
    logic [TW-1:0] tag;
    logic          dbz;
    logic          tmo;
    int            pulses;
  } exp_t;

  typedef struct {
    logic [M-1:0]  dd;
    logic [N-1:0]  dv;
    logic [TW-1:0] tag;
    logic [QW-1:0] q;
    logic          dbz;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pulse_cnt = 0;
  logic tog_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: what the sequencer must answer for a request, from plain arithmetic.
  function automatic exp_t model(input logic [M-1:0] dd, input logic [N-1:0] dv,
                                 input logic [TW-1:0] t, input logic stuck);
    exp_t e;
    e.tag = t; e.dbz = 1'b0; e.tmo = 1'b0; e.pulses = 1;
    if (dv == 0) begin
      e.q = '1; e.dbz = 1'b1; e.pulses = 0;
    end else if (stuck) begin
      e.q = '0; e.tmo = 1'b1;
    end else begin
      e.q = QW'(int'(dd) / int'(dv));
    end
    return e;
  endfunction

  // Clock-enable toggler for the gated-clock scenario.
  always @(posedge clk) begin
    #1;
    if (tog_en) clk_en = ~clk_en;
  end

  logic en_at_edge = 1'b1;
  always @(posedge clk) en_at_edge <= clk_en;

  // Monitor: scoreboard on accept/retire, stability on disabled edges, handshake exclusion.
  logic [48:0] snap_prev = '0, snap_now;
  logic        rst_prev = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    snap_now = {rsp_valid, rsp_quotient, rsp_tag, rsp_dbz, rsp_tmo, div_divide,
                div_dividend, div_divisor, busy};
    if (!rst && !rst_prev && !en_at_edge) chk("hold_when_disabled", snap_now, snap_prev);
    if (!rst) begin
      chk("ready_valid_exclusive", rsp_valid & req_ready, 0);
      if (req_valid && req_ready) sb.push_back(model(req_dividend, req_divisor, req_tag, stub_stuck));
      if (div_divide && clk_en) pulse_cnt++;
      if (rsp_valid && rsp_ready && clk_en) begin
        chk("rsp_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_quotient", rsp_quotient, e.q);
          chk("sb_tag", rsp_tag, e.tag);
          chk("sb_dbz", rsp_dbz, e.dbz);
          chk("sb_tmo", rsp_tmo, e.tmo);
          chk("sb_divide_pulses", pulse_cnt, e.pulses);
        end
        pulse_cnt = 0;
      end
    end
    snap_prev = snap_now;
    rst_prev  = rst;
  end

  // Present a request and return at the first falling edge after it is accepted.
  task automatic send(input logic [M-1:0] dd, input logic [N-1:0] dv, input logic [TW-1:0] t);
    int n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_dividend = dd; req_divisor = dv; req_tag = t;
    @(negedge clk);
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", n < 300, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_in_time", lat < 300, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("retire_in_time", n < 300, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vt[6];
    int            lat;
    logic [QW-1:0] q0;
    logic [M-1:0]  rdd;
    logic [N-1:0]  rdv;
    logic [TW-1:0] rtg;

    vt[0] = '{dd: 16'd100,   dv: 8'd7,   tag: 4'd3, q: 16'd14,    dbz: 1'b0};
    vt[1] = '{dd: 16'd0,     dv: 8'd1,   tag: 4'd1, q: 16'd0,     dbz: 1'b0};
    vt[2] = '{dd: 16'd65535, dv: 8'd1,   tag: 4'd2, q: 16'd65535, dbz: 1'b0};
    vt[3] = '{dd: 16'd1234,  dv: 8'd0,   tag: 4'd5, q: 16'hFFFF,  dbz: 1'b1};
    vt[4] = '{dd: 16'd255,   dv: 8'd255, tag: 4'd6, q: 16'd1,     dbz: 1'b0};
    vt[5] = '{dd: 16'd65535, dv: 8'd255, tag: 4'd7, q: 16'd257,   dbz: 1'b0};

    rst = 1'b1; clk_en = 1'b1; req_valid = 1'b0; req_dividend = '0; req_divisor = '0;
    req_tag = '0; rsp_ready = 1'b1; stub_stuck = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", {rsp_valid, rsp_quotient, rsp_tag, rsp_dbz, rsp_tmo, div_divide,
                          div_dividend, div_divisor, busy}, 0);
    chk("reset_req_ready", req_ready, 1);
    @(posedge clk); #1 rst = 1'b0;

    // Directed table, back-to-back with the response port always ready
    for (int i = 0; i < 6; i++) begin
      send(vt[i].dd, vt[i].dv, vt[i].tag);
      chk("busy_after_accept", busy, 1);
      chk("ready_low_while_busy", req_ready, 0);
      if (vt[i].dbz) begin
        chk("dbz_valid_next_cycle", rsp_valid, 1);
        chk("dbz_no_divide", div_divide, 0);
      end else begin
        chk("divide_next_cycle", div_divide, 1);
        chk("dividend_latched", div_dividend, vt[i].dd);
        chk("divisor_latched", div_divisor, vt[i].dv);
      end
      wait_rsp(lat);
      if (!vt[i].dbz) chk("div_path_latency", lat, LAT + 2);
      chk("vec_quotient", rsp_quotient, vt[i].q);
      chk("vec_tag", rsp_tag, vt[i].tag);
      chk("vec_dbz", rsp_dbz, vt[i].dbz);
      chk("vec_tmo", rsp_tmo, 0);
      @(negedge clk);
      wait_idle();
    end

    // Response back-pressure: result held, new request refused
    @(posedge clk); #1 rsp_ready = 1'b0;
    send(16'd500, 8'd5, 4'd4);
    wait_rsp(lat);
    q0 = rsp_quotient;
    chk("bp_quotient", q0, 16'd100);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_dividend = 16'd9; req_divisor = 8'd3; req_tag = 4'd8;
      @(negedge clk);
      chk("bp_valid_held", rsp_valid, 1);
      chk("bp_quotient_stable", rsp_quotient, q0);
      chk("bp_tag_stable", rsp_tag, 4'd4);
      chk("bp_no_accept", req_ready, 0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    wait_idle();

    // Clock enable toggling every cycle
    @(negedge clk); tog_en = 1'b1;
    send(16'd40000, 8'd200, 4'd10);
    wait_rsp(lat);
    chk("gated_quotient", rsp_quotient, 16'd200);
    chk("gated_tag", rsp_tag, 4'd10);
    wait_idle();
    @(negedge clk); #2;
    tog_en = 1'b0; clk_en = 1'b1;

    // Asynchronous reset while waiting for done: silent abort
    send(16'd500, 8'd5, 4'd11);
    repeat (6) @(negedge clk);
    chk("midop_busy", busy, 1);
    #2 clk_en = 1'b0; rst = 1'b1;
    #1;
    chk("async_reset_outputs", {rsp_valid, rsp_quotient, rsp_tag, rsp_dbz, rsp_tmo, div_divide,
                                div_dividend, div_divisor, busy}, 0);
    sb.delete();
    pulse_cnt = 0;
    @(posedge clk); #1 clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("no_rsp_after_abort", rsp_valid, 0);
    end

    // Divider never signals done: timeout
    @(posedge clk); #1 stub_stuck = 1'b1;
    send(16'd77, 8'd3, 4'd12);
    chk("tmo_divide_pulse", div_divide, 1);
    wait_rsp(lat);
    chk("tmo_latency", lat, TO + 1);
    chk("tmo_flag", rsp_tmo, 1);
    chk("tmo_quotient", rsp_quotient, 0);
    chk("tmo_dbz", rsp_dbz, 0);
    chk("tmo_tag", rsp_tag, 4'd12);
    @(negedge clk);
    wait_idle();
    @(posedge clk); #1 stub_stuck = 1'b0;

    // Randomized requests with random response back-pressure, checked by the scoreboard
    for (int i = 0; i < 40; i++) begin
      rdd = 16'($urandom);
      rdv = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      rtg = 4'($urandom);
      @(posedge clk); #1 rsp_ready = 1'($urandom_range(0, 1));
      send(rdd, rdv, rtg);
      wait_rsp(lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(negedge clk);
      wait_idle();
    end

    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
